gpio_pad_ring: RTL and testbench

Parametrised GPIO pad ring for the chip top: a configurable number of bidirectional `pad_io` cells with per-channel input conditioning. Each pad input is synchronised into the `clk` domain, optionally debounced, and edge-detected into sticky, maskable interrupt status for the core. Pad output drivers stay tristated after reset until the core explicitly releases them.

---
 rtl/gpio_pad_pkg.sv | 20 ++
 rtl/gpio_pad_chan.sv | 100 ++++++++++
 rtl/gpio_pad_ring.sv | 96 +++++++++
 tb/tb_gpio_pad_ring.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_pkg.sv
// rtl/gpio_pad_pkg.sv - shared limits and channel state type for the GPIO pad ring
//
// Contents:
//   GPIO_MAX          largest supported channel count
//   SYNC_MAX          deepest supported input synchroniser
//   FILT_MAX_W        widest supported debounce counter
//   gpio_chan_state_t per-channel conditioning state (filtered level, counter, sync chain)
package gpio_pad_pkg;

    localparam int GPIO_MAX   = 64;
    localparam int SYNC_MAX   = 4;
    localparam int FILT_MAX_W = 8;

    typedef struct packed {
        logic                  filtered;
        logic [FILT_MAX_W-1:0] counter;
        logic [SYNC_MAX-1:0]   sync;
    } gpio_chan_state_t;

endpackage

// File: rtl/gpio_pad_chan.sv
// rtl/gpio_pad_chan.sv - one GPIO channel: pad cell, synchroniser, debounce, edge detect
//
// Optional feature macro: GPIO_PAD_FILTER_EN (debounce counter present when defined;
// otherwise the filtered level is a single register stage after the synchroniser).
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   pad          bidirectional chip pad
//   pad_out      pad drive value
//   pad_en       pad drive enable (already gated by the release flag)
//   filt_thresh  debounce threshold (unused without GPIO_PAD_FILTER_EN)
//   level        conditioned input level
//   rise, fall   registered one-cycle pulses on conditioned transitions
//   edge_set     combinational: level updates on the coming edge
module gpio_pad_chan
    import gpio_pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire               pad,
    input  logic              pad_out,
    input  logic              pad_en,
    input  logic [FILT_W-1:0] filt_thresh,
    output logic              level,
    output logic              rise,
    output logic              fall,
    output logic              edge_set
);

    logic                   pad_in;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   upd;

    // Pad cell: tristate driver plus input receiver.
    assign pad    = pad_en ? pad_out : 1'bz;
    assign pad_in = pad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_PAD_FILTER_EN
    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_d;

    // The counter only advances while below the live threshold, so it can
    // never wrap; lowering the threshold mid-count takes effect at once.
    always_comb begin
        upd   = 1'b0;
        cnt_d = cnt_q;
        if (sync == level) begin
            cnt_d = '0;
        end else if (cnt_q >= filt_thresh) begin
            upd   = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^filt_thresh;
    assign upd           = (sync != level);
`endif

    assign edge_set = upd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            if (upd) begin
                level <= sync;
            end
            rise <= upd & sync;
            fall <= upd & ~sync;
        end
    end

endmodule

// File: rtl/gpio_pad_ring.sv
// rtl/gpio_pad_ring.sv - GPIO pad ring top: release flag, per-channel conditioning, sticky irq status
//
// Optional feature macro: GPIO_PAD_FILTER_EN (per-channel debounce using core_filt_thresh).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   gpio              chip pads (inout)
//   core_gpio_out     pad drive value
//   core_gpio_en      pad drive enable per channel
//   core_pad_release  level; pad drivers enabled once seen high (sticky until reset)
//   core_filt_thresh  shared debounce threshold
//   core_gpio_in      conditioned input level
//   core_gpio_rise    one-cycle pulse on conditioned 0->1
//   core_gpio_fall    one-cycle pulse on conditioned 1->0
//   core_irq_mask     1 = channel contributes to core_irq
//   core_irq_clear    per-bit status clear pulse
//   core_irq_status   sticky edge status
//   core_irq          registered OR of status & mask
module gpio_pad_ring
    import gpio_pad_pkg::*;
#(
    parameter int NUM_GPIO    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic                clk,
    input  logic                reset,
    inout  wire  [NUM_GPIO-1:0] gpio,
    input  logic [NUM_GPIO-1:0] core_gpio_out,
    input  logic [NUM_GPIO-1:0] core_gpio_en,
    input  logic                core_pad_release,
    input  logic [FILT_W-1:0]   core_filt_thresh,
    output logic [NUM_GPIO-1:0] core_gpio_in,
    output logic [NUM_GPIO-1:0] core_gpio_rise,
    output logic [NUM_GPIO-1:0] core_gpio_fall,
    input  logic [NUM_GPIO-1:0] core_irq_mask,
    input  logic [NUM_GPIO-1:0] core_irq_clear,
    output logic [NUM_GPIO-1:0] core_irq_status,
    output logic                core_irq
);

    if (NUM_GPIO < 1 || NUM_GPIO > GPIO_MAX) begin : g_bad_num_gpio
        $error("gpio_pad_ring: NUM_GPIO out of range");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync_stages
        $error("gpio_pad_ring: SYNC_STAGES out of range");
    end

    logic                rel_flag_q;
    logic [NUM_GPIO-1:0] edge_set;
    logic [NUM_GPIO-1:0] status_q;
    logic                irq_q;

    // Pads stay tristated from reset until the core releases them once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rel_flag_q <= 1'b0;
        end else if (core_pad_release) begin
            rel_flag_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_chan
        gpio_pad_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .pad         (gpio[i]),
            .pad_out     (core_gpio_out[i]),
            .pad_en      (core_gpio_en[i] & rel_flag_q),
            .filt_thresh (core_filt_thresh),
            .level       (core_gpio_in[i]),
            .rise        (core_gpio_rise[i]),
            .fall        (core_gpio_fall[i]),
            .edge_set    (edge_set[i])
        );
    end

    // Status uses the channel's next-edge flag so the bit lands on the same
    // edge as the registered rise/fall pulse; a new edge beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= (status_q & ~core_irq_clear) | edge_set;
            irq_q    <= |(status_q & core_irq_mask);
        end
    end

    assign core_irq_status = status_q;
    assign core_irq        = irq_q;

endmodule

// File: tb/tb_gpio_pad_ring.sv
// tb/tb_gpio_pad_ring.sv - self-checking bench for gpio_pad_ring
module tb_gpio_pad_ring;

    localparam int N    = 8;
    localparam int SYNC = 2;
    localparam int FW   = 4;
`ifdef GPIO_PAD_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic          clk;
    logic          reset;
    wire  [N-1:0]  gpio;
    logic [N-1:0]  core_gpio_out;
    logic [N-1:0]  core_gpio_en;
    logic          core_pad_release;
    logic [FW-1:0] core_filt_thresh;
    logic [N-1:0]  core_gpio_in;
    logic [N-1:0]  core_gpio_rise;
    logic [N-1:0]  core_gpio_fall;
    logic [N-1:0]  core_irq_mask;
    logic [N-1:0]  core_irq_clear;
    logic [N-1:0]  core_irq_status;
    logic          core_irq;

    logic [N-1:0]  tb_en;
    logic [N-1:0]  tb_val;

    int errors = 0;
    int checks = 0;

    gpio_pad_ring #(
        .NUM_GPIO    (N),
        .SYNC_STAGES (SYNC),
        .FILT_W      (FW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .gpio             (gpio),
        .core_gpio_out    (core_gpio_out),
        .core_gpio_en     (core_gpio_en),
        .core_pad_release (core_pad_release),
        .core_filt_thresh (core_filt_thresh),
        .core_gpio_in     (core_gpio_in),
        .core_gpio_rise   (core_gpio_rise),
        .core_gpio_fall   (core_gpio_fall),
        .core_irq_mask    (core_irq_mask),
        .core_irq_clear   (core_irq_clear),
        .core_irq_status  (core_irq_status),
        .core_irq         (core_irq)
    );

    for (genvar i = 0; i < N; i++) begin : g_pad
        assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] out;
        logic [N-1:0] tbv;
        logic [N-1:0] exp_pad;
    } pad_vec_t;

    pad_vec_t vecs [5];

    function automatic int lat(input int thr);
        return SYNC + (FILT ? thr : 0) + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Count posedges until core_gpio_in[ch] == val; 0 if the bound expires.
    task automatic wait_level(input int ch, input logic val, output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (core_gpio_in[ch] == val) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic pulse_clear(input logic [N-1:0] bits);
        @(negedge clk);
        core_irq_clear = bits;
        @(negedge clk);
        core_irq_clear = '0;
    endtask

    initial begin
        int  n;
        logic saw;

        vecs[0] = '{en: 8'hF0, out: 8'hA0, tbv: 8'h05, exp_pad: 8'hA5};
        vecs[1] = '{en: 8'hF0, out: 8'h50, tbv: 8'h0A, exp_pad: 8'h5A};
        vecs[2] = '{en: 8'hFF, out: 8'h3C, tbv: 8'h00, exp_pad: 8'h3C};
        vecs[3] = '{en: 8'h00, out: 8'hFF, tbv: 8'hC3, exp_pad: 8'hC3};
        vecs[4] = '{en: 8'h0F, out: 8'h09, tbv: 8'h60, exp_pad: 8'h69};

        reset            = 1'b0;
        core_gpio_out    = 8'hFF;
        core_gpio_en     = 8'hFF;
        core_pad_release = 1'b0;
        core_filt_thresh = '0;
        core_irq_mask    = '0;
        core_irq_clear   = '0;
        tb_en            = 8'hFF;
        tb_val           = 8'h00;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_gpio_in", core_gpio_in, 0);
        check("reset_rise", core_gpio_rise, 0);
        check("reset_fall", core_gpio_fall, 0);
        check("reset_status", core_irq_status, 0);
        check("reset_irq", core_irq, 0);

        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("pads_tristate_before_release", gpio, 8'h00);

        @(negedge clk);
        core_gpio_en = 8'hF0;
        tb_en        = 8'h0F;
        @(negedge clk);
        core_pad_release = 1'b1;
        @(posedge clk); #1;
        check("pads_driven_after_release", gpio, 8'hF0);
        @(negedge clk);
        core_pad_release = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("release_sticky", gpio, 8'hF0);

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            core_gpio_en  = vecs[v].en;
            core_gpio_out = vecs[v].out;
            tb_en         = ~vecs[v].en;
            tb_val        = vecs[v].tbv;
            #1 check($sformatf("pad_vec%0d", v), gpio, vecs[v].exp_pad);
        end

        @(negedge clk);
        core_gpio_en  = 8'hF0;
        core_gpio_out = 8'h00;
        tb_en         = 8'h0F;
        tb_val        = 8'h00;
        repeat (10) @(negedge clk);
        pulse_clear(8'hFF);
        #1 check("status_cleared", core_irq_status, 0);

        // Latency, pulse, status, irq masking on channel 0.
        core_filt_thresh = 4'd3;
        repeat (2) @(negedge clk);
        tb_val[0] = 1'b1;
        wait_level(0, 1'b1, n);
        check("latency_thr3", n, lat(3));
        check("rise_pulse", core_gpio_rise[0], 1);
        check("status_set_with_pulse", core_irq_status, 8'h01);
        @(posedge clk); #1;
        check("rise_one_cycle", core_gpio_rise[0], 0);
        check("irq_masked", core_irq, 0);
        @(negedge clk);
        core_irq_mask = 8'h01;
        @(posedge clk); #1;
        check("irq_after_mask", core_irq, 1);

        pulse_clear(8'h01);
        check("status_clear_bit0", core_irq_status[0], 0);

        // Clear coinciding with a fall edge: set wins.
        @(negedge clk);
        tb_val[0] = 1'b0;
        repeat (lat(3) - 1) @(posedge clk);
        @(negedge clk);
        core_irq_clear = 8'h01;
        @(posedge clk); #1;
        check("fall_pulse", core_gpio_fall[0], 1);
        check("set_wins_over_clear", core_irq_status[0], 1);
        @(negedge clk);
        core_irq_clear = '0;
        core_irq_mask  = '0;
        pulse_clear(8'hFF);

        // Glitch filter on channel 1.
        @(negedge clk);
        tb_val[1] = 1'b1;
        repeat (3) @(negedge clk);
        tb_val[1] = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch3_status", core_irq_status[1], FILT ? 0 : 1);
        check("glitch3_level", core_gpio_in[1], 0);
        pulse_clear(8'h02);

        @(negedge clk);
        tb_val[1] = 1'b1;
        repeat (4) @(negedge clk);
        tb_val[1] = 1'b0;
        n   = 0;
        saw = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (core_gpio_rise[1]) saw = 1'b1;
            if (core_gpio_fall[1]) begin
                n = k;
                break;
            end
        end
        check("glitch4_fall_latency", n, lat(3));
        check("glitch4_status", core_irq_status[1], 1);
        check("glitch4_rise_seen", saw | (FILT ? 1'b0 : 1'b1), 1);

        // Threshold lowered mid-count on channel 2.
        @(negedge clk);
        core_filt_thresh = 4'd15;
        @(negedge clk);
        tb_val[2] = 1'b1;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (core_gpio_in[2]) begin
                n = k;
                break;
            end
            if (k == 10) core_filt_thresh = 4'd2;
        end
        check("thresh_drop_latency", n, FILT ? 11 : 3);

        // Reset mid-count with pad 3 high.
        @(negedge clk);
        core_filt_thresh = 4'd3;
        core_gpio_out    = 8'h80;
        @(negedge clk);
        tb_val[3] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        tb_en[7]  = 1'b1;
        tb_val[7] = 1'b0;
        #1;
        check("midreset_gpio_in", core_gpio_in, 0);
        check("midreset_status", core_irq_status, 0);
        check("midreset_rise_fall", {core_gpio_rise, core_gpio_fall}, 0);
        check("midreset_irq", core_irq, 0);
        check("midreset_pad_released", gpio[7], 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_level(3, 1'b1, n);
        check("powerup_rise_latency", n, lat(3));
        check("powerup_rise_pulse", core_gpio_rise[3], 1);
        check("powerup_status", core_irq_status[3], 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
